// File: rtl/st7066u_read_operation.sv
// ST7066U LCD read-cycle sequencer: drives RS/RW/E with datasheet timing, samples DB on E fall,
// and optionally re-polls the busy flag until BF=0 or a poll limit is reached.
module st7066u_read_operation #(
  parameter int unsigned SETUP_TICKS   = 2,
  parameter int unsigned E_HIGH_TICKS  = 12,
  parameter int unsigned HOLD_TICKS    = 1,
  parameter int unsigned RECOVER_TICKS = 45,
  parameter int unsigned MAX_POLLS     = 255
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ena,
  input  logic       i_start,
  input  logic       i_rs,
  input  logic       i_poll,
  input  logic [7:0] i_db,
  output logic       o_rs,
  output logic       o_rw,
  output logic       o_e,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_data,
  output logic       o_timeout
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_TICKS - 1);
  localparam logic [CNT_W-1:0] E_HIGH_LAST  = CNT_W'(E_HIGH_TICKS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(RECOVER_TICKS - 1);
  localparam logic [7:0]       POLL_MAX     = 8'(MAX_POLLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_E_HIGH,
    S_HOLD,
    S_RECOVER
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_d;
  logic             rw_q, rw_d;
  logic             e_q, e_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       data_q, data_d;
  logic             timeout_q, timeout_d;
  logic             poll_en_q, poll_en_d;
  logic [7:0]       poll_cnt_q, poll_cnt_d;
  logic             tick_last;
  logic             phase_end;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      e_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
      timeout_q  <= 1'b0;
      poll_en_q  <= 1'b0;
      poll_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rs_q       <= rs_d;
      rw_q       <= rw_d;
      e_q        <= e_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_q     <= data_d;
      timeout_q  <= timeout_d;
      poll_en_q  <= poll_en_d;
      poll_cnt_q <= poll_cnt_d;
    end
  end

  always_comb begin
    tick_last = 1'b0;
    unique case (state_q)
      S_SETUP:   tick_last = (cnt_q == SETUP_LAST);
      S_E_HIGH:  tick_last = (cnt_q == E_HIGH_LAST);
      S_HOLD:    tick_last = (cnt_q == HOLD_LAST);
      S_RECOVER: tick_last = (cnt_q == RECOVER_LAST);
      default:   tick_last = 1'b0;
    endcase
  end

  assign phase_end = i_ena & tick_last;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rs_d       = rs_q;
    rw_d       = rw_q;
    e_d        = e_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    data_d     = data_q;
    timeout_d  = 1'b0;
    poll_en_d  = poll_en_q;
    poll_cnt_d = poll_cnt_q;

    // The phase counter restarts on every state change; idle ticks are never counted.
    if (state_q != S_IDLE && i_ena) begin
      cnt_d = tick_last ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        rw_d  = 1'b0;
        e_d   = 1'b0;
        cnt_d = '0;
        if (i_start) begin
          state_d    = S_SETUP;
          rs_d       = i_rs;
          poll_en_d  = i_poll & ~i_rs;
          rw_d       = 1'b1;
          busy_d     = 1'b1;
          poll_cnt_d = '0;
        end
      end
      S_SETUP: begin
        if (phase_end) begin
          state_d = S_E_HIGH;
          e_d     = 1'b1;
        end
      end
      S_E_HIGH: begin
        if (phase_end) begin
          state_d = S_HOLD;
          e_d     = 1'b0;
          data_d  = i_db;
          if (poll_cnt_q != POLL_MAX) begin
            poll_cnt_d = poll_cnt_q + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (phase_end) begin
          state_d = S_RECOVER;
          rw_d    = 1'b0;
        end
      end
      S_RECOVER: begin
        if (phase_end) begin
          if (poll_en_q && data_q[7] && (poll_cnt_q < POLL_MAX)) begin
            state_d = S_SETUP;
            rw_d    = 1'b1;
          end else begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            timeout_d = poll_en_q & data_q[7];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_rs      = rs_q;
  assign o_rw      = rw_q;
  assign o_e       = e_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_data    = data_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_st7066u_read_operation.sv
// Directed bench for the ST7066U read sequencer: default instance plus a MAX_POLLS=3 instance.
module tb_st7066u_read_operation;

  logic       clk;
  logic       i_reset;
  logic       i_start;
  logic       i_rs;
  logic       i_poll;
  logic [7:0] i_db;
  logic       i_ena;
  logic       sel;
  logic       start_a, start_b;

  logic       rs_a, rw_a, e_a, busy_a, done_a, to_a;
  logic [7:0] data_a;
  logic       rs_b, rw_b, e_b, busy_b, done_b, to_b;
  logic [7:0] data_b;

  logic       rs_s, rw_s, e_s, busy_s, done_s, to_s;
  logic [7:0] data_s;

  logic       ena_mode;
  int         div;
  logic       use_seq;
  logic [7:0] db_fix;
  int         base;

  int         pulses, ehigh, dones, tos;
  logic       e_prev;

  int         n_assert, n_fail;
  logic       exp_rs;
  logic       rs_bad;
  int         lat, e_first;
  int         p0, h0, d0, t0;

  st7066u_read_operation dut_a (
    .i_clk(clk), .i_reset(i_reset), .i_ena(i_ena), .i_start(start_a), .i_rs(i_rs),
    .i_poll(i_poll), .i_db(i_db), .o_rs(rs_a), .o_rw(rw_a), .o_e(e_a), .o_busy(busy_a),
    .o_done(done_a), .o_data(data_a), .o_timeout(to_a)
  );

  st7066u_read_operation #(.MAX_POLLS(3)) dut_b (
    .i_clk(clk), .i_reset(i_reset), .i_ena(i_ena), .i_start(start_b), .i_rs(i_rs),
    .i_poll(i_poll), .i_db(i_db), .o_rs(rs_b), .o_rw(rw_b), .o_e(e_b), .o_busy(busy_b),
    .o_done(done_b), .o_data(data_b), .o_timeout(to_b)
  );

  assign start_a = i_start & ~sel;
  assign start_b = i_start & sel;
  assign rs_s    = sel ? rs_b   : rs_a;
  assign rw_s    = sel ? rw_b   : rw_a;
  assign e_s     = sel ? e_b    : e_a;
  assign busy_s  = sel ? busy_b : busy_a;
  assign done_s  = sel ? done_b : done_a;
  assign to_s    = sel ? to_b   : to_a;
  assign data_s  = sel ? data_b : data_a;

  assign i_ena = ena_mode ? (div == 0) : 1'b1;
  assign i_db  = use_seq ? (((pulses - base) <= 3) ? 8'h85 : 8'h05) : db_fix;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) div <= (div == 4) ? 0 : div + 1;

  // Observes the selected instance mid-high-phase, well before the bench's negedge reads.
  always @(posedge clk) begin
    #2;
    if (e_s && !e_prev) pulses = pulses + 1;
    if (e_s) ehigh = ehigh + 1;
    if (done_s) dones = dones + 1;
    if (to_s) tos = tos + 1;
    e_prev = e_s;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    p0 = pulses; h0 = ehigh; d0 = dones; t0 = tos;
  endtask

  task automatic run(input string tag, input int restart_at, input int budget,
                     output int lat_o, output int e_first_o);
    int cyc;
    e_first_o = 0;
    rs_bad = 1'b0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    cyc = 1;
    forever begin
      if (e_s && e_first_o == 0) e_first_o = cyc;
      if (busy_s && rs_s !== exp_rs) rs_bad = 1'b1;
      if (done_s || cyc >= budget) break;
      i_start = (cyc == restart_at);
      @(negedge clk);
      cyc++;
    end
    i_start = 1'b0;
    lat_o = cyc;
    check({tag, "_done_seen"}, 32'(done_s), 32'd1);
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    pulses = 0; ehigh = 0; dones = 0; tos = 0; e_prev = 1'b0;
    div = 0; ena_mode = 1'b0; use_seq = 1'b0; db_fix = 8'h00; base = 0;
    sel = 1'b0; i_start = 1'b0; i_rs = 1'b0; i_poll = 1'b0; exp_rs = 1'b0;
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rs", 32'(rs_a), 32'd0);
    check("rst_rw", 32'(rw_a), 32'd0);
    check("rst_e", 32'(e_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_data", 32'(data_a), 32'h00);
    check("rst_timeout", 32'(to_a), 32'd0);
    i_reset = 1'b0;
    @(negedge clk);

    // 1: single data read
    i_rs = 1'b1; exp_rs = 1'b1; db_fix = 8'hA5; snap();
    run("t1", 0, 100, lat, e_first);
    check("t1_latency", 32'(lat), 32'd61);
    check("t1_e_first", 32'(e_first), 32'd3);
    check("t1_e_high_clks", 32'(ehigh - h0), 32'd12);
    check("t1_pulses", 32'(pulses - p0), 32'd1);
    check("t1_data", 32'(data_s), 32'hA5);
    check("t1_rw_idle", 32'(rw_s), 32'd0);
    check("t1_busy_off", 32'(busy_s), 32'd0);
    check("t1_timeout", 32'(to_s), 32'd0);
    check("t1_rs_stable", 32'(rs_bad), 32'd0);
    @(negedge clk);
    check("t1_done_1clk", 32'(done_s), 32'd0);

    // 2: busy-flag poll, BF clears on the fourth read
    i_rs = 1'b0; exp_rs = 1'b0; i_poll = 1'b1; base = pulses; use_seq = 1'b1; snap();
    run("t2", 0, 400, lat, e_first);
    check("t2_latency", 32'(lat), 32'd241);
    check("t2_pulses", 32'(pulses - p0), 32'd4);
    check("t2_data", 32'(data_s), 32'h05);
    check("t2_timeout", 32'(to_s), 32'd0);
    check("t2_rs_stable", 32'(rs_bad), 32'd0);
    use_seq = 1'b0;
    repeat (2) @(negedge clk);

    // 3: poll limit of 3 with BF stuck high
    sel = 1'b1; db_fix = 8'h80;
    repeat (2) @(negedge clk);
    snap();
    run("t3", 0, 400, lat, e_first);
    check("t3_latency", 32'(lat), 32'd181);
    check("t3_pulses", 32'(pulses - p0), 32'd3);
    check("t3_timeout_with_done", 32'(to_s), 32'd1);
    check("t3_data", 32'(data_s), 32'h80);
    @(negedge clk);
    check("t3_timeout_count", 32'(tos - t0), 32'd1);
    sel = 1'b0; i_poll = 1'b0;
    repeat (2) @(negedge clk);

    // 4: tick on one clock in five
    i_rs = 1'b1; exp_rs = 1'b1; db_fix = 8'h3C; ena_mode = 1'b1; snap();
    run("t4", 0, 400, lat, e_first);
    check("t4_latency_range", 32'((lat >= 297) && (lat <= 301)), 32'd1);
    check("t4_e_high_clks", 32'(ehigh - h0), 32'd60);
    check("t4_pulses", 32'(pulses - p0), 32'd1);
    check("t4_data", 32'(data_s), 32'h3C);
    repeat (20) @(negedge clk);
    check("t4_single_done", 32'(dones - d0), 32'd1);
    ena_mode = 1'b0;

    // 5: reset while E is high
    db_fix = 8'h5A; snap();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (e_s) break;
      @(negedge clk);
    end
    check("t5_e_reached", 32'(e_s), 32'd1);
    i_reset = 1'b1;
    @(negedge clk);
    check("t5_e_drop", 32'(e_s), 32'd0);
    check("t5_rw_drop", 32'(rw_s), 32'd0);
    check("t5_busy_drop", 32'(busy_s), 32'd0);
    check("t5_no_done", 32'(done_s), 32'd0);
    i_reset = 1'b0;
    repeat (70) @(negedge clk);
    check("t5_no_done_after", 32'(dones - d0), 32'd0);
    run("t5_fresh", 0, 100, lat, e_first);
    check("t5_fresh_latency", 32'(lat), 32'd61);
    check("t5_fresh_data", 32'(data_s), 32'h5A);

    // 6: repeat start while busy, poll requested on a data read
    i_rs = 1'b1; exp_rs = 1'b1; i_poll = 1'b1; db_fix = 8'h81; snap();
    run("t6", 10, 100, lat, e_first);
    check("t6_latency", 32'(lat), 32'd61);
    check("t6_timeout", 32'(to_s), 32'd0);
    check("t6_rs_stable", 32'(rs_bad), 32'd0);
    repeat (80) @(negedge clk);
    check("t6_pulses", 32'(pulses - p0), 32'd1);
    check("t6_single_done", 32'(dones - d0), 32'd1);
    check("t6_idle_busy", 32'(busy_s), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
